// File: rtl/digit_reg_pkg.sv
// rtl/digit_reg_pkg.sv - command encoding and slot select codes for the digit entry register
package digit_reg_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP   = 3'd0;
  localparam logic [CMD_W-1:0] CMD_PUSH  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_BACK  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 3'd3;
  localparam logic [CMD_W-1:0] CMD_LOAD  = 3'd4;
  localparam logic [CMD_W-1:0] CMD_ROTL  = 3'd5;

  // What every slot does on the next edge; all slots share one select.
  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_LEFT  = 3'd1,
    SEL_RIGHT = 3'd2,
    SEL_LOAD  = 3'd3,
    SEL_ZERO  = 3'd4
  } slot_sel_e;

endpackage

// File: rtl/digit_slot.sv
// rtl/digit_slot.sv - one digit register with neighbour/load/zero input mux
module digit_slot
  import digit_reg_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  slot_sel_e     sel,
  input  logic [DW-1:0] left,
  input  logic [DW-1:0] right,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] q
);

  // Select the next digit value; left moves digits towards the MSBs, right towards slot 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LEFT:  q <= left;
        SEL_RIGHT: q <= right;
        SEL_LOAD:  q <= load_val;
        SEL_ZERO:  q <= '0;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/digit_entry_register.sv
// rtl/digit_entry_register.sv - keypad digit shift register with push/back/clear/load/rotate
module digit_entry_register
  import digit_reg_pkg::*;
#(
  parameter  int DIGITS = 8,
  parameter  int DW     = 4,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 cmd_valid,
  input  logic [CMD_W-1:0]     cmd,
  input  logic [DW-1:0]        din,
  input  logic [DIGITS*DW-1:0] load_data,
  input  logic [CW-1:0]        load_count,
  output logic [DIGITS*DW-1:0] digits,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 err
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DIGITS);

  logic [DW-1:0] slot_q [DIGITS];
  logic [DW-1:0] slot0_left;
  slot_sel_e     sel;
  logic          rotate;
  logic          reject;
  logic          sampled;
  logic [CW-1:0] count_nxt;

  assign sampled    = ce & cmd_valid;
  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign slot0_left = rotate ? slot_q[DIGITS-1] : din;

  // Decode the sampled command; a rejected command leaves sel at HOLD and the count untouched.
  always_comb begin
    sel       = SEL_HOLD;
    rotate    = 1'b0;
    reject    = 1'b0;
    count_nxt = count;
    if (sampled) begin
      case (cmd)
        CMD_NOP: ;
        CMD_PUSH: begin
          if (full) begin
            reject = 1'b1;
          end else begin
            sel       = SEL_LEFT;
            count_nxt = count + CW'(1);
          end
        end
        CMD_BACK: begin
          if (empty) begin
            reject = 1'b1;
          end else begin
            sel       = SEL_RIGHT;
            count_nxt = count - CW'(1);
          end
        end
        CMD_CLEAR: begin
          sel       = SEL_ZERO;
          count_nxt = '0;
        end
        CMD_LOAD: begin
          if (load_count > FULL_COUNT) begin
            reject = 1'b1;
          end else begin
            sel       = SEL_LOAD;
            count_nxt = load_count;
          end
        end
        CMD_ROTL: begin
          sel    = SEL_LEFT;
          rotate = 1'b1;
        end
        default: reject = 1'b1;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_slot
      logic [DW-1:0] left_in;
      logic [DW-1:0] right_in;

      if (i == 0) begin : g_left_first
        assign left_in = slot0_left;
      end else begin : g_left_chain
        assign left_in = slot_q[i-1];
      end

      if (i == DIGITS - 1) begin : g_right_last
        assign right_in = '0;
      end else begin : g_right_chain
        assign right_in = slot_q[i+1];
      end

      digit_slot #(.DW(DW)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .left     (left_in),
        .right    (right_in),
        .load_val (load_data[i*DW +: DW]),
        .q        (slot_q[i])
      );

      assign digits[i*DW +: DW] = slot_q[i];
    end
  endgenerate

  // Count and error pulse; err reflects only the command sampled at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      err   <= reject;
    end
  end

endmodule
